// File: rtl/ethernet_mmio_arbiter_if.sv
// Bundle of requester-side handshakes and the Ethernet controller register port.
// The arbiter connects through the slave modport; the environment (requesters
// plus controller) uses the master modport.
interface ethernet_mmio_arbiter_if #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 14,
  parameter int num_req_p    = 2
);
  localparam int mask_w = data_width_p / 8;

  logic [num_req_p-1:0]              req_v_i;
  logic [num_req_p-1:0]              req_ready_o;
  logic [num_req_p-1:0]              req_w_i;
  logic [num_req_p*addr_width_p-1:0] req_addr_i;
  logic [num_req_p*mask_w-1:0]       req_mask_i;
  logic [num_req_p*data_width_p-1:0] req_data_i;
  logic [num_req_p-1:0]              resp_v_o;
  logic [data_width_p-1:0]           resp_data_o;
  logic [num_req_p-1:0]              resp_yumi_i;
  logic [addr_width_p-1:0]           addr_o;
  logic                              write_en_o;
  logic                              read_en_o;
  logic [mask_w-1:0]                 write_mask_o;
  logic [data_width_p-1:0]           write_data_o;
  logic [data_width_p-1:0]           read_data_i;

  modport slave (
    input  req_v_i, req_w_i, req_addr_i, req_mask_i, req_data_i, resp_yumi_i, read_data_i,
    output req_ready_o, resp_v_o, resp_data_o, addr_o, write_en_o, read_en_o,
           write_mask_o, write_data_o
  );

  modport master (
    output req_v_i, req_w_i, req_addr_i, req_mask_i, req_data_i, resp_yumi_i, read_data_i,
    input  req_ready_o, resp_v_o, resp_data_o, addr_o, write_en_o, read_en_o,
           write_mask_o, write_data_o
  );
endinterface

// File: rtl/ethernet_mmio_arbiter.sv
// Round-robin arbiter/sequencer sharing the Ethernet controller's synchronous-read
// register port between up to four requesters. One access is in flight at a time:
// grant in IDLE, strobe in ISSUE, capture late read data in CAPTURE, then hold the
// response in RESP until the owning requester takes it.
module ethernet_mmio_arbiter #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 14,
  parameter int num_req_p    = 2
) (
  input logic clk_i,
  input logic reset_i,
  ethernet_mmio_arbiter_if.slave bus
);
  localparam int mask_w = data_width_p / 8;
  localparam int id_w   = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam logic [id_w-1:0] last_id = id_w'(num_req_p - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]              state_r;
  logic [id_w-1:0]         ptr_r;
  logic [id_w-1:0]         id_r;
  logic                    w_r;
  logic [addr_width_p-1:0] addr_r;
  logic [mask_w-1:0]       mask_r;
  logic [data_width_p-1:0] data_r;
  logic [data_width_p-1:0] resp_data_r;

  logic                    found;
  logic [id_w-1:0]         gnt_id;
  logic [id_w-1:0]         scan_id;
  logic [id_w-1:0]         ptr_next;
  logic                    accept;
  logic [num_req_p-1:0]    ready;
  logic [num_req_p-1:0]    resp_v;

  // Search for the first valid requester starting at the priority pointer, wrapping around.
  always_comb begin
    found   = 1'b0;
    gnt_id  = '0;
    scan_id = ptr_r;
    for (int i = 0; i < num_req_p; i++) begin
      if (!found && bus.req_v_i[scan_id]) begin
        found  = 1'b1;
        gnt_id = scan_id;
      end
      scan_id = (scan_id == last_id) ? '0 : scan_id + 1'b1;
    end
  end

  // A single requester leaves last_id at 0, so the pointer stays pinned at 0.
  assign ptr_next = (gnt_id == last_id) ? '0 : gnt_id + 1'b1;
  assign accept   = (state_r == IDLE) && found && !reset_i;

  // One-hot ready and response-valid vectors; both forced low while reset is asserted.
  always_comb begin
    ready  = '0;
    resp_v = '0;
    if (accept) ready[gnt_id] = 1'b1;
    if ((state_r == RESP) && !reset_i) resp_v[id_r] = 1'b1;
  end

  // Access sequencer: latch the granted request, strobe once, collect data, wait for yumi.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      id_r        <= '0;
      w_r         <= 1'b0;
      addr_r      <= '0;
      mask_r      <= '0;
      data_r      <= '0;
      resp_data_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found) begin
            id_r    <= gnt_id;
            w_r     <= bus.req_w_i[gnt_id];
            addr_r  <= bus.req_addr_i[gnt_id*addr_width_p +: addr_width_p];
            mask_r  <= bus.req_mask_i[gnt_id*mask_w +: mask_w];
            data_r  <= bus.req_data_i[gnt_id*data_width_p +: data_width_p];
            ptr_r   <= ptr_next;
            state_r <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_r) begin
            resp_data_r <= '0;
            state_r     <= RESP;
          end else begin
            state_r <= CAPTURE;
          end
        end
        CAPTURE: begin
          resp_data_r <= bus.read_data_i;
          state_r     <= RESP;
        end
        RESP: begin
          if (bus.resp_yumi_i[id_r]) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // The latched fields only change on a grant, so the controller bus holds its last access.
  assign bus.req_ready_o  = ready;
  assign bus.resp_v_o     = resp_v;
  assign bus.resp_data_o  = reset_i ? '0 : resp_data_r;
  assign bus.addr_o       = reset_i ? '0 : addr_r;
  assign bus.write_mask_o = reset_i ? '0 : mask_r;
  assign bus.write_data_o = reset_i ? '0 : data_r;
  assign bus.write_en_o   = (state_r == ISSUE) && w_r && !reset_i;
  assign bus.read_en_o    = (state_r == ISSUE) && !w_r && !reset_i;
endmodule

// File: doc/ethernet_mmio_arbiter.md
# ethernet_mmio_arbiter

Round-robin arbiter and sequencer that lets up to four requesters (host core, DMA engine, debug port) share the single synchronous-read MMIO register port of the Ethernet controller. Each requester presents valid/ready requests and receives one valid/yumi response per request. The block serialises accesses and drives the controller's single-cycle write/read strobes. It captures the one-cycle-late read data and routes it back to the originating requester.

## Interface
- data_width_p, 32, register data width; must match the Ethernet controller
- addr_width_p, 14, register address width
- num_req_p, 2, number of requesters, legal 1..4
- clk_i  in  1  single clock, same domain as the controller's register port
- reset_i  in  1  synchronous, active-high reset
- req_v_i  in  num_req_p  request valid, one bit per requester
- req_ready_o  out  num_req_p  request accepted this cycle, at most one bit high
- req_w_i  in  num_req_p  1 = write, 0 = read
- req_addr_i  in  num_req_p*addr_width_p  packed request addresses
- req_mask_i  in  num_req_p*data_width_p/8  packed byte write masks
- req_data_i  in  num_req_p*data_width_p  packed write data
- resp_v_o  out  num_req_p  response valid, at most one bit high
- resp_data_o  out  data_width_p  read data; 0 for write responses
- resp_yumi_i  in  num_req_p  requester consumes its response
- addr_o  out  addr_width_p  controller address
- write_en_o  out  1  controller write strobe
- read_en_o  out  1  controller read strobe
- write_mask_o  out  data_width_p/8  controller byte mask
- write_data_o  out  data_width_p  controller write data
- read_data_i  in  data_width_p  controller read data, valid the cycle after read_en_o

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - Grant goes to the first requester with req_v_i set, searching from priority pointer ptr_r upward with wrap-around.
  - req_ready_o[grant] is high combinationally in the same cycle.
  - On grant, latch id, w, addr, mask and data; advance ptr_r to (grant+1) mod num_req_p; go to ISSUE.
  - With no req_v_i set: stay in IDLE and leave ptr_r unchanged.
- ISSUE:
  - Drive addr_o, write_mask_o and write_data_o from the latched request.
  - Pulse write_en_o or read_en_o for exactly one cycle, never both.
  - Write: go to RESP, with the response data register set to 0.
  - Read: go to CAPTURE.
- CAPTURE: register read_data_i into the response data register; go to RESP.
- RESP:
  - Hold resp_v_o[id] high and resp_data_o stable until resp_yumi_i[id]; then go to IDLE.
  - No grant in RESP. A new grant is possible no earlier than the cycle after yumi.
  - resp_yumi_i on any other bit, or outside RESP, is ignored.
- Outside ISSUE: write_en_o and read_en_o are 0. addr_o, write_mask_o and write_data_o hold their last values.
- num_req_p = 1: ptr_r is constant 0; behaviour is otherwise identical.
- Invalid requests are not checked: a requester that drops req_v_i before ready simply is not granted.

## Timing
- Reset (reset_i high at a clock edge):
  - state = IDLE, ptr_r = 0, all latched fields = 0.
  - Outputs during and after reset: req_ready_o, resp_v_o, write_en_o and read_en_o are 0; resp_data_o, addr_o, write_mask_o and write_data_o are 0.
  - req_ready_o may assert in the first cycle after reset deasserts.
- Reset mid-operation aborts the access with no response. A strobe in the reset cycle is suppressed.
- Accept in cycle N:
  - Strobe in cycle N+1.
  - Read response visible from N+3; write response visible from N+2.
- Minimum spacing between back-to-back accesses with immediate yumi: 4 cycles for reads, 3 for writes.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,num_req_p-1,0.

## Test plan
- Single read, num_req_p=2:
  - Stimulus: req 0 reads addr 0x0010; controller returns 0xDEADBEEF the cycle after read_en_o; yumi immediate.
  - Required: ready at N, read_en_o only at N+1 with addr_o=0x0010, resp_v_o=2'b01 with data 0xDEADBEEF at N+3, IDLE at N+4.
- Write:
  - Stimulus: req 1 writes 0x12345678 with mask 4'b0101 to 0x0004.
  - Required: write_en_o one cycle at N+1 with those values; resp_v_o=2'b10 with data 0 at N+2.
- Contention:
  - Stimulus: both requesters continuously valid with reads for 8 accesses.
  - Required: grant order 0,1,0,1,...; one strobe per access; every response routed to the correct id.
- Backpressure:
  - Stimulus: hold resp_yumi_i low for 5 cycles in RESP while the controller's read_data_i changes.
  - Required: resp_data_o stable; no req_ready_o and no strobes until the cycle after yumi.
- Reset mid-access:
  - Stimulus: assert reset_i in the ISSUE cycle.
  - Required: no strobe that cycle; all outputs 0; no response; ptr_r=0; next grant goes to requester 0.
- Wrap-around, num_req_p=3:
  - Stimulus: after a grant to 2, requesters 0 and 2 are valid.
  - Required: requester 0 is granted first.
